// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: issues dmem loads/stores, extends load data, drives the RF write port.
// Optional define MEMWB_MISALIGN_TRAP_EN traps misaligned H/W accesses on o_misaligned.
module mem_wb_stage #(
   parameter int unsigned RF_ADDR_W   = 5,
   parameter int unsigned RSP_TIMEOUT = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_ex_valid,
   output logic                 o_ex_ready,
   input  logic [31:0]          i_ex_result,
   input  logic [RF_ADDR_W-1:0] i_ex_rd,
   input  logic                 i_ex_is_load,
   input  logic                 i_ex_is_store,
   input  logic [2:0]           i_ex_funct3,
   input  logic [31:0]          i_ex_store_data,
   input  logic                 i_flush,
   output logic                 o_stall,
   output logic                 o_dmem_req,
   output logic                 o_dmem_we,
   output logic [31:0]          o_dmem_addr,
   output logic [3:0]           o_dmem_be,
   output logic [31:0]          o_dmem_wdata,
   input  logic                 i_dmem_gnt,
   input  logic                 i_dmem_rvalid,
   input  logic [31:0]          i_dmem_rdata,
   output logic                 o_rf_we,
   output logic [RF_ADDR_W-1:0] o_rf_waddr,
   output logic [31:0]          o_rf_wdata,
`ifdef MEMWB_MISALIGN_TRAP_EN
   output logic                 o_bus_err,
   output logic                 o_misaligned
`else
   output logic                 o_bus_err
`endif
);

   localparam int unsigned CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StWb} state_e;

   state_e                 state_q;
   logic [31:0]            result_q;
   logic [RF_ADDR_W-1:0]   rd_q;
   logic                   is_load_q;
   logic                   is_store_q;
   logic [2:0]             funct3_q;
   logic [31:0]            sdata_q;
   logic [31:0]            wb_data_q;
   logic                   kill_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   bus_err_q;
`ifdef MEMWB_MISALIGN_TRAP_EN
   logic                   misal_q;
`endif

   logic [1:0]  off;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] load_ext;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic        capture;
   logic        timeout;
   logic        misaligned;

   assign off = result_q[1:0];

   // Size comes from funct3[1:0]; shifted enables are truncated to the word.
   always_comb begin
      be       = 4'b1111;
      wdata    = sdata_q;
      lane_b   = i_dmem_rdata[{off, 3'b000} +: 8];
      lane_h   = i_dmem_rdata[{off[1], 4'b0000} +: 16];
      load_ext = i_dmem_rdata;
      case (funct3_q[1:0])
         2'b00: begin
            be    = 4'b0001 << off;
            wdata = {4{sdata_q[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << off;
            wdata = {2{sdata_q[15:0]}};
         end
         default: ;
      endcase
      case (funct3_q)
         3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
         3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
         3'b100:  load_ext = {24'd0, lane_b};
         3'b101:  load_ext = {16'd0, lane_h};
         default: load_ext = i_dmem_rdata;
      endcase
   end

`ifdef MEMWB_MISALIGN_TRAP_EN
   assign misaligned = ((funct3_q[1:0] == 2'b01) && off[0]) || (funct3_q[1] && (off != 2'b00));
   assign o_misaligned = misal_q;
`else
   assign misaligned = 1'b0;
`endif

   assign capture = i_ex_valid && o_ex_ready && !i_flush;
   assign timeout = (RSP_TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == RSP_TIMEOUT);

   assign o_ex_ready   = (state_q == StIdle) || (state_q == StWb);
   assign o_stall      = (state_q == StReq) || (state_q == StWait);
   assign o_dmem_req   = (state_q == StReq) && !misaligned;
   assign o_dmem_we    = (state_q == StReq) && is_store_q;
   assign o_dmem_addr  = (state_q == StReq) ? {result_q[31:2], 2'b00} : 32'd0;
   assign o_dmem_be    = (state_q == StReq) ? be : 4'd0;
   assign o_dmem_wdata = ((state_q == StReq) && is_store_q) ? wdata : 32'd0;
   assign o_rf_we      = (state_q == StWb) && (rd_q != '0);
   assign o_rf_waddr   = rd_q;
   assign o_rf_wdata   = wb_data_q;
   assign o_bus_err    = bus_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         result_q   <= '0;
         rd_q       <= '0;
         is_load_q  <= 1'b0;
         is_store_q <= 1'b0;
         funct3_q   <= '0;
         sdata_q    <= '0;
         wb_data_q  <= '0;
         kill_q     <= 1'b0;
         cnt_q      <= '0;
         bus_err_q  <= 1'b0;
`ifdef MEMWB_MISALIGN_TRAP_EN
         misal_q    <= 1'b0;
`endif
      end else begin
         bus_err_q <= 1'b0;
`ifdef MEMWB_MISALIGN_TRAP_EN
         misal_q   <= 1'b0;
`endif
         unique case (state_q)
            StIdle, StWb: begin
               if (capture) begin
                  result_q   <= i_ex_result;
                  rd_q       <= i_ex_rd;
                  is_load_q  <= i_ex_is_load;
                  is_store_q <= i_ex_is_store;
                  funct3_q   <= i_ex_funct3;
                  sdata_q    <= i_ex_store_data;
                  wb_data_q  <= i_ex_result;
                  kill_q     <= 1'b0;
                  state_q    <= (i_ex_is_load || i_ex_is_store) ? StReq : StWb;
               end else begin
                  state_q <= StIdle;
               end
            end
            StReq: begin
               if (misaligned) begin
`ifdef MEMWB_MISALIGN_TRAP_EN
                  misal_q <= !i_flush;
`endif
                  state_q <= StIdle;
               end else if (i_dmem_gnt) begin
                  // A grant coincident with flush stands; a load then completes as killed.
                  if (is_load_q) begin
                     kill_q  <= i_flush;
                     cnt_q   <= '0;
                     state_q <= StWait;
                  end else begin
                     state_q <= StIdle;
                  end
               end else if (i_flush) begin
                  state_q <= StIdle;
               end
            end
            StWait: begin
               if (i_dmem_rvalid) begin
                  if (kill_q || i_flush) begin
                     state_q <= StIdle;
                  end else begin
                     wb_data_q <= load_ext;
                     state_q   <= StWb;
                  end
               end else if (timeout) begin
                  bus_err_q <= 1'b1;
                  state_q   <= StIdle;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (i_flush) kill_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed corner cases plus randomized ops vs a reference model.
module tb_mem_wb_stage;

   localparam int unsigned RF_ADDR_W   = 5;
   localparam int unsigned RSP_TIMEOUT = 4;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 i_ex_valid;
   logic                 o_ex_ready;
   logic [31:0]          i_ex_result;
   logic [RF_ADDR_W-1:0] i_ex_rd;
   logic                 i_ex_is_load;
   logic                 i_ex_is_store;
   logic [2:0]           i_ex_funct3;
   logic [31:0]          i_ex_store_data;
   logic                 i_flush;
   logic                 o_stall;
   logic                 o_dmem_req;
   logic                 o_dmem_we;
   logic [31:0]          o_dmem_addr;
   logic [3:0]           o_dmem_be;
   logic [31:0]          o_dmem_wdata;
   logic                 i_dmem_gnt;
   logic                 i_dmem_rvalid;
   logic [31:0]          i_dmem_rdata;
   logic                 o_rf_we;
   logic [RF_ADDR_W-1:0] o_rf_waddr;
   logic [31:0]          o_rf_wdata;
   logic                 o_bus_err;
`ifdef MEMWB_MISALIGN_TRAP_EN
   logic                 o_misaligned;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

   mem_wb_stage #(
      .RF_ADDR_W   (RF_ADDR_W),
      .RSP_TIMEOUT (RSP_TIMEOUT)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_ex_valid      (i_ex_valid),
      .o_ex_ready      (o_ex_ready),
      .i_ex_result     (i_ex_result),
      .i_ex_rd         (i_ex_rd),
      .i_ex_is_load    (i_ex_is_load),
      .i_ex_is_store   (i_ex_is_store),
      .i_ex_funct3     (i_ex_funct3),
      .i_ex_store_data (i_ex_store_data),
      .i_flush         (i_flush),
      .o_stall         (o_stall),
      .o_dmem_req      (o_dmem_req),
      .o_dmem_we       (o_dmem_we),
      .o_dmem_addr     (o_dmem_addr),
      .o_dmem_be       (o_dmem_be),
      .o_dmem_wdata    (o_dmem_wdata),
      .i_dmem_gnt      (i_dmem_gnt),
      .i_dmem_rvalid   (i_dmem_rvalid),
      .i_dmem_rdata    (i_dmem_rdata),
      .o_rf_we         (o_rf_we),
      .o_rf_waddr      (o_rf_waddr),
      .o_rf_wdata      (o_rf_wdata),
`ifdef MEMWB_MISALIGN_TRAP_EN
      .o_bus_err       (o_bus_err),
      .o_misaligned    (o_misaligned)
`else
      .o_bus_err       (o_bus_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: byte enables, replicated store data and extended load data.
   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
      int off;
      off = int'(a[1:0]);
      if (f3[1:0] == 2'd0) return 4'((1 << off) & 15);
      if (f3[1:0] == 2'd1) return 4'((3 << off) & 15);
      return 4'hF;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
      if (f3[1:0] == 2'd0) return {24'd0, sd[7:0]} * 32'h0101_0101;
      if (f3[1:0] == 2'd1) return {16'd0, sd[15:0]} * 32'h0001_0001;
      return sd;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rdata);
      int off;
      logic [31:0] b, h;
      off = int'(a[1:0]);
      b = (rdata >> (8 * off)) & 32'hFF;
      h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
         3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return rdata;
      endcase
   endfunction

`ifdef MEMWB_MISALIGN_TRAP_EN
   function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
      return ((f3[1:0] == 2'd1) && (a[0] == 1'b1)) || ((f3[1:0] >= 2'd2) && (a[1:0] != 2'd0));
   endfunction
`endif

   task automatic drive_op(input bit ld, input bit st, input logic [2:0] f3,
                           input logic [31:0] r, input logic [4:0] rd, input logic [31:0] sd);
      i_ex_valid      = 1'b1;
      i_ex_is_load    = ld;
      i_ex_is_store   = st;
      i_ex_funct3     = f3;
      i_ex_result     = r;
      i_ex_rd         = rd;
      i_ex_store_data = sd;
   endtask

   // Single ALU op from IDLE; expects the write in the following cycle, then IDLE.
   task automatic alu_op(input logic [31:0] r, input logic [4:0] rd);
      chk("alu_ready", o_ex_ready, 1);
      drive_op(1'b0, 1'b0, 3'($urandom_range(0, 7)), r, rd, $urandom);
      @(negedge clk);
      i_ex_valid = 1'b0;
      chk("alu_rf_we", o_rf_we, rd != 0);
      chk("alu_waddr", o_rf_waddr, rd);
      chk("alu_wdata", o_rf_wdata, r);
      chk("alu_stall", o_stall, 0);
      @(negedge clk);
      chk("alu_idle_we", o_rf_we, 0);
   endtask

   // Load or store from IDLE with bench-controlled grant and response latency.
   task automatic mem_op(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] sd, input int gnt_dly,
                         input int rsp_dly, input logic [31:0] rdata);
      chk("mem_ready", o_ex_ready, 1);
      drive_op(ld, !ld, f3, a, rd, sd);
      @(negedge clk);
      i_ex_valid = 1'b0;
`ifdef MEMWB_MISALIGN_TRAP_EN
      if (ref_misaligned(f3, a)) begin
         chk("mis_req", o_dmem_req, 0);
         chk("mis_stall", o_stall, 1);
         @(negedge clk);
         chk("mis_pulse", o_misaligned, 1);
         chk("mis_rf_we", o_rf_we, 0);
         chk("mis_ready", o_ex_ready, 1);
         @(negedge clk);
         chk("mis_pulse_end", o_misaligned, 0);
         return;
      end
`endif
      for (int i = 0; i <= gnt_dly; i++) begin
         chk("req", o_dmem_req, 1);
         chk("req_stall", o_stall, 1);
         chk("req_ready", o_ex_ready, 0);
         chk("req_addr", o_dmem_addr, {a[31:2], 2'b00});
         chk("req_be", o_dmem_be, ref_be(f3, a));
         chk("req_we", o_dmem_we, !ld);
         if (!ld) chk("req_wdata", o_dmem_wdata, ref_wdata(f3, sd));
         i_dmem_gnt = (i == gnt_dly);
         @(negedge clk);
      end
      i_dmem_gnt = 1'b0;
      if (!ld) begin
         chk("st_done_stall", o_stall, 0);
         chk("st_done_req", o_dmem_req, 0);
         chk("st_done_rf_we", o_rf_we, 0);
         chk("st_done_ready", o_ex_ready, 1);
         return;
      end
      for (int i = 0; i <= rsp_dly; i++) begin
         chk("wait_stall", o_stall, 1);
         chk("wait_req", o_dmem_req, 0);
         chk("wait_rf_we", o_rf_we, 0);
         i_dmem_rvalid = (i == rsp_dly);
         i_dmem_rdata  = (i == rsp_dly) ? rdata : $urandom;
         @(negedge clk);
      end
      i_dmem_rvalid = 1'b0;
      chk("ld_rf_we", o_rf_we, rd != 0);
      chk("ld_waddr", o_rf_waddr, rd);
      chk("ld_wdata", o_rf_wdata, ref_load(f3, a, rdata));
      chk("ld_stall", o_stall, 0);
      chk("ld_ready", o_ex_ready, 1);
      @(negedge clk);
      chk("ld_idle_we", o_rf_we, 0);
   endtask

   // Load accepted and granted immediately; returns at the first WAIT-cycle negedge.
   task automatic load_to_wait(input logic [31:0] a, input logic [4:0] rd);
      drive_op(1'b1, 1'b0, 3'd2, a, rd, 32'd0);
      @(negedge clk);
      i_ex_valid = 1'b0;
      i_dmem_gnt = 1'b1;
      @(negedge clk);
      i_dmem_gnt = 1'b0;
   endtask

   initial begin
      i_ex_valid = 0; i_ex_result = 0; i_ex_rd = 0; i_ex_is_load = 0; i_ex_is_store = 0;
      i_ex_funct3 = 0; i_ex_store_data = 0; i_flush = 0; i_dmem_gnt = 0; i_dmem_rvalid = 0;
      i_dmem_rdata = 0;
      #12;
      chk("rst_ready", o_ex_ready, 1);
      chk("rst_stall", o_stall, 0);
      chk("rst_req", o_dmem_req, 0);
      chk("rst_we", o_dmem_we, 0);
      chk("rst_addr", o_dmem_addr, 0);
      chk("rst_be", o_dmem_be, 0);
      chk("rst_wdata", o_dmem_wdata, 0);
      chk("rst_rf_we", o_rf_we, 0);
      chk("rst_waddr", o_rf_waddr, 0);
      chk("rst_rf_wdata", o_rf_wdata, 0);
      chk("rst_bus_err", o_bus_err, 0);
`ifdef MEMWB_MISALIGN_TRAP_EN
      chk("rst_misaligned", o_misaligned, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ALU back-to-back, then rd=0.
      drive_op(1'b0, 1'b0, 3'd0, 32'h4, 5'd3, 32'd0);
      @(negedge clk);
      chk("b2b_we0", o_rf_we, 1);
      chk("b2b_waddr0", o_rf_waddr, 3);
      chk("b2b_wdata0", o_rf_wdata, 32'h4);
      chk("b2b_ready0", o_ex_ready, 1);
      drive_op(1'b0, 1'b0, 3'd0, 32'h8, 5'd4, 32'd0);
      @(negedge clk);
      chk("b2b_we1", o_rf_we, 1);
      chk("b2b_waddr1", o_rf_waddr, 4);
      chk("b2b_wdata1", o_rf_wdata, 32'h8);
      drive_op(1'b0, 1'b0, 3'd0, 32'hC, 5'd0, 32'd0);
      @(negedge clk);
      i_ex_valid = 1'b0;
      chk("b2b_rd0_we", o_rf_we, 0);
      @(negedge clk);
      chk("b2b_idle_we", o_rf_we, 0);

      // Directed loads/stores.
      mem_op(1'b1, 3'd0, 32'h1003, 5'd5, 32'd0, 2, 0, 32'h80AA_BBCC);
      mem_op(1'b1, 3'd5, 32'h2002, 5'd6, 32'd0, 0, 1, 32'h9234_5678);
      mem_op(1'b0, 3'd0, 32'h10, 5'd7, 32'h5A, 1, 0, 32'd0);
      mem_op(1'b0, 3'd1, 32'h23, 5'd7, 32'hBEEF, 0, 0, 32'd0);

      // Flush in WB: the older write completes, the new op is blocked.
      drive_op(1'b0, 1'b0, 3'd0, 32'h77, 5'd9, 32'd0);
      @(negedge clk);
      chk("wbflush_we", o_rf_we, 1);
      drive_op(1'b1, 1'b0, 3'd2, 32'h100, 5'd10, 32'd0);
      i_flush = 1'b1;
      @(negedge clk);
      i_flush = 1'b0;
      i_ex_valid = 1'b0;
      chk("wbflush_no_capture", o_stall, 0);
      chk("wbflush_idle_we", o_rf_we, 0);

      // Flush in REQ without grant withdraws the request.
      drive_op(1'b1, 1'b0, 3'd2, 32'h200, 5'd11, 32'd0);
      @(negedge clk);
      i_ex_valid = 1'b0;
      chk("reqflush_req", o_dmem_req, 1);
      i_flush = 1'b1;
      @(negedge clk);
      i_flush = 1'b0;
      chk("reqflush_req_drop", o_dmem_req, 0);
      chk("reqflush_ready", o_ex_ready, 1);

      // Flush coincident with grant on a load: waits for response, no write.
      drive_op(1'b1, 1'b0, 3'd2, 32'h300, 5'd12, 32'd0);
      @(negedge clk);
      i_ex_valid = 1'b0;
      i_flush = 1'b1;
      i_dmem_gnt = 1'b1;
      @(negedge clk);
      i_flush = 1'b0;
      i_dmem_gnt = 1'b0;
      chk("gntflush_wait", o_stall, 1);
      i_dmem_rvalid = 1'b1;
      i_dmem_rdata = 32'h1234_5678;
      @(negedge clk);
      i_dmem_rvalid = 1'b0;
      chk("gntflush_rf_we", o_rf_we, 0);
      chk("gntflush_ready", o_ex_ready, 1);

      // Flush in WAIT, response three cycles later.
      load_to_wait(32'h400, 5'd13);
      chk("waitflush_stall", o_stall, 1);
      i_flush = 1'b1;
      @(negedge clk);
      i_flush = 1'b0;
      @(negedge clk);
      @(negedge clk);
      i_dmem_rvalid = 1'b1;
      i_dmem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      i_dmem_rvalid = 1'b0;
      chk("waitflush_rf_we", o_rf_we, 0);
      chk("waitflush_ready", o_ex_ready, 1);
      chk("waitflush_bus_err", o_bus_err, 0);

      // Response timeout.
      load_to_wait(32'h500, 5'd14);
      for (int i = 0; i < 4; i++) begin
         chk("to_wait_stall", o_stall, 1);
         chk("to_no_err", o_bus_err, 0);
         @(negedge clk);
      end
      chk("to_bus_err", o_bus_err, 1);
      chk("to_stall", o_stall, 0);
      chk("to_rf_we", o_rf_we, 0);
      @(negedge clk);
      chk("to_bus_err_end", o_bus_err, 0);

      // Reset mid-transaction; a late response is ignored.
      load_to_wait(32'h600, 5'd15);
      rst_n = 1'b0;
      #2;
      chk("midrst_ready", o_ex_ready, 1);
      chk("midrst_stall", o_stall, 0);
      @(negedge clk);
      rst_n = 1'b1;
      i_dmem_rvalid = 1'b1;
      i_dmem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      i_dmem_rvalid = 1'b0;
      chk("midrst_rf_we", o_rf_we, 0);
      chk("midrst_ready2", o_ex_ready, 1);

      // Randomized ops.
      for (int n = 0; n < 60; n++) begin
         int kind;
         logic [4:0] rd;
         kind = $urandom_range(0, 2);
         rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         if (kind == 0) alu_op($urandom, rd);
         else if (kind == 1)
            mem_op(1'b1, ld_f3[$urandom_range(0, 4)], $urandom, rd, 32'd0,
                   $urandom_range(0, 2), $urandom_range(0, 3), $urandom);
         else
            mem_op(1'b0, 3'($urandom_range(0, 2)), $urandom, rd, $urandom,
                   $urandom_range(0, 2), 0, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory/writeback stage downstream of the execute stage; consumes its 32-bit result and control with a valid/ready handshake.
- Issues data-memory requests for loads and stores, sign/zero-extends load data, and drives the register-file write port.
- Asserts o_stall back to execute while a memory transaction is outstanding; honours pipeline flush.

Parameters:
RF_ADDR_W, 5, register-file address width
RSP_TIMEOUT, 0, max cycles in WAIT before bus error; 0 disables the timeout counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_ex_valid  input  1  execute result valid
o_ex_ready  output  1  stage can accept a result this cycle
i_ex_result  input  32  ALU result or effective address
i_ex_rd  input  RF_ADDR_W  destination register
i_ex_is_load  input  1  memory read op
i_ex_is_store  input  1  memory write op (exclusive with is_load)
i_ex_funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
i_ex_store_data  input  32  store source data
i_flush  input  1  kill younger/in-flight op
o_stall  output  1  stall request to upstream stages
o_dmem_req  output  1  memory request valid
o_dmem_we  output  1  1 = store
o_dmem_addr  output  32  word-aligned address {result[31:2],2'b00}
o_dmem_be  output  4  byte enables
o_dmem_wdata  output  32  lane-replicated store data
i_dmem_gnt  input  1  request accepted this cycle
i_dmem_rvalid  input  1  load response valid
i_dmem_rdata  input  32  load response word
o_rf_we  output  1  register-file write strobe
o_rf_waddr  output  RF_ADDR_W  write address
o_rf_wdata  output  32  write data
o_bus_err  output  1  one-cycle pulse on response timeout

Behaviour:
- Reset: state IDLE; all outputs 0 except o_ex_ready=1; captured fields cleared; kill flag cleared.
- States IDLE, REQ, WAIT, WB. o_ex_ready=1 in IDLE and WB only. o_stall=1 in REQ and WAIT.
- Capture: i_ex_valid && o_ex_ready && !i_flush at a rising edge latches all i_ex_* fields. Next state: REQ if load/store, otherwise WB.
- WB: o_rf_we=1 for exactly one cycle if rd!=0; o_rf_waddr=rd; o_rf_wdata=result for ALU ops, extended data for loads. A new op may be captured in the same cycle (back-to-back, 1 result/cycle for ALU ops). With no capture, next state is IDLE.
- ALU latency: capture edge -> o_rf_we high in the following cycle.
- REQ: o_dmem_req=1; addr/we/be/wdata held stable until i_dmem_gnt. On gnt: a store goes to IDLE with no RF write; a load goes to WAIT.
- Byte enables (off=result[1:0]): B 4'b0001<<off; H 4'b0011<<off; W 4'b1111; shifts truncated to 4 bits.
- wdata: B {4{sd[7:0]}}, H {2{sd[15:0]}}, W sd.
- WAIT: on i_dmem_rvalid, select the lane by off: B=rdata[8*off+:8]; H uses the halfword at off[1]. Sign-extend for funct3 000/001, zero-extend for 100/101, whole word for 010. Then go to WB.
- rvalid outside WAIT is ignored.
- Flush:
  - In IDLE/WB: blocks capture; an RF write in WB this cycle still completes (the op is older).
  - In REQ: request withdrawn, go to IDLE; the memory side tolerates req deassertion before gnt.
  - In WAIT: kill flag is set, the response is still consumed, then go to IDLE without writing.
  - Flush coincident with gnt in REQ: the grant stands; a store is performed, a load goes to WAIT with kill set.
- Timeout (RSP_TIMEOUT>0): a counter is cleared on WAIT entry and increments each WAIT cycle. When it reaches RSP_TIMEOUT with no rvalid: o_bus_err pulses one cycle, no RF write, go to IDLE.
- Reset mid-transaction: immediate return to IDLE; the outstanding response is not tracked after reset.

Optional Feature:
- MEMWB_MISALIGN_TRAP_EN
- Defined:
  - Misalignment is H with off[0]=1, or W with off!=0.
  - A misaligned load/store goes IDLE->REQ as normal, but in REQ o_dmem_req stays 0.
  - Output o_misaligned pulses for 1 cycle, no RF write, next state IDLE.
  - o_misaligned is reset to 0.
- Undefined: the o_misaligned port is absent; misaligned accesses use the truncated byte enables and lane selection above.

Test Plan:
- ALU back-to-back: results 0x4, 0x8 on rd=3,4 in consecutive cycles -> o_rf_we two consecutive cycles, wdata 0x4 then 0x8; rd=0 -> no write.
- LB at addr 0x1003, gnt 2 cycles late, rdata 0x80AA_BBCC -> o_stall high from capture until response; be=1000 held; rf_wdata 0xFFFF_FF80.
- LHU at 0x2002, rdata 0x9234_5678 -> rf_wdata 0x0000_9234.
- SB 0x5A at 0x10 -> be=0001, wdata 0x5A5A_5A5A, we=1, no RF write, IDLE after gnt.
- Flush in WAIT: load outstanding, i_flush=1, rvalid 3 cycles later -> no o_rf_we, o_ex_ready=1 next cycle.
- RSP_TIMEOUT=4, no rvalid -> o_bus_err pulses after 4 WAIT cycles; with MEMWB_MISALIGN_TRAP_EN, LW at 0x6 -> o_misaligned pulse, o_dmem_req never asserted.
